// File: rtl/base_emux_arb.sv
// rtl/base_emux_arb.sv - round-robin requester arbiter with credit flow control for base_emux_mc
// Optional sticky credit-protocol error flag: BASE_EMUX_ARB_PERR_EN
module base_emux_arb #(
    parameter int ways       = 4,
    parameter int sel_width  = $clog2(ways),
    parameter int credits    = 8,
    parameter int cred_width = $clog2(credits + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ways-1]       i_v,
    output logic [0:ways-1]       i_r,
    output logic                  o_v,
    output logic [0:sel_width-1]  o_sel,
    input  logic                  i_cred,
    output logic [0:cred_width-1] o_cred,
    output logic                  o_perr
);

    logic [sel_width-1:0]  ptr;
    logic [cred_width-1:0] cred;
    logic [0:ways-1]       gnt;
    logic [sel_width-1:0]  gidx;
    logic                  found;
    logic                  avail;
    logic                  full;

    assign avail = (cred != '0);
    assign full  = (cred == cred_width'(credits));

    // Search starts just after the last winner; reset holds every grant off.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        if (!reset && avail) begin
            for (int k = 1; k <= ways; k++) begin
                if (!found && i_v[(int'(ptr) + k) % ways]) begin
                    found = 1'b1;
                    gnt[(int'(ptr) + k) % ways] = 1'b1;
                    gidx  = sel_width'((int'(ptr) + k) % ways);
                end
            end
        end
    end

    assign i_r    = gnt;
    assign o_v    = |(i_v & i_r);
    assign o_sel  = o_v ? gidx : '0;
    assign o_cred = cred;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr  <= sel_width'(ways - 1);
            cred <= cred_width'(credits);
        end else begin
            if (o_v) begin
                ptr <= gidx;
            end
            case ({o_v, i_cred})
                2'b10: cred <= cred - 1'b1;
                2'b01: if (!full) cred <= cred + 1'b1;
                default: cred <= cred;
            endcase
        end
    end

`ifdef BASE_EMUX_ARB_PERR_EN
    logic perr;

    always_ff @(posedge clk) begin
        if (reset) begin
            perr <= 1'b0;
        end else if (i_cred && full) begin
            perr <= 1'b1;
        end
    end

    assign o_perr = perr;
`else
    assign o_perr = 1'b0;
`endif

endmodule
